// File: rtl/apu_pkg.sv
// apu_pkg: command codes, record layout and sequencer state encoding
package apu_pkg;
    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_DLY  = 8'h02;
    localparam logic [7:0] CMD_POLL = 8'h03;
    localparam logic [7:0] CMD_END  = 8'hFF;
    localparam int REC_LEN = 4;
    typedef enum logic [3:0] {
        IDLE, F_CMD, F_ALO, F_AHI, F_DAT, EXEC,
        IO_WR, IO_RD, POLL_GAP, DELAY, DONE, ERR
    } state_t;
endpackage

// File: rtl/apu_io_master.sv
// apu_io_master: level request/ack handshake for writes and polled reads with retry gap
module apu_io_master #(
    parameter int MAX_POLL = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_go,
    input  logic        i_rd_go,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_io_ack,
    input  logic [7:0]  i_io_rdata,
    output logic        o_io_wr,
    output logic        o_io_rd,
    output logic [15:0] o_io_addr,
    output logic [7:0]  o_io_wdata,
    output logic        o_wr_done,
    output logic        o_rd_match,
    output logic        o_rd_retry,
    output logic        o_rd_fail
);
    localparam int CW = $clog2(MAX_POLL + 1);
    logic [CW-1:0] r_att;
    logic [7:0]    r_expect;
    logic          r_gap;
    logic          w_wr_ack, w_rd_ack, w_hit, w_last;
    assign w_wr_ack   = i_io_ack & o_io_wr;
    assign w_rd_ack   = i_io_ack & o_io_rd;
    assign w_hit      = i_io_rdata == r_expect;
    assign w_last     = r_att == CW'(MAX_POLL);
    assign o_wr_done  = w_wr_ack;
    assign o_rd_match = w_rd_ack & w_hit;
    assign o_rd_retry = w_rd_ack & ~w_hit & ~w_last;
    assign o_rd_fail  = w_rd_ack & ~w_hit & w_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            o_io_wr    <= 1'b0;
            o_io_rd    <= 1'b0;
            o_io_addr  <= '0;
            o_io_wdata <= '0;
            r_expect   <= '0;
            r_att      <= '0;
            r_gap      <= 1'b0;
        end else if (i_wr_go) begin
            o_io_wr    <= 1'b1;
            o_io_addr  <= i_addr;
            o_io_wdata <= i_data;
        end else if (i_rd_go) begin
            o_io_rd   <= 1'b1;
            o_io_addr <= i_addr;
            r_expect  <= i_data;
            r_att     <= CW'(1);
        end else if (r_gap) begin
            r_gap   <= 1'b0;
            o_io_rd <= 1'b1;
            r_att   <= r_att + 1'b1;
        end else begin
            if (w_wr_ack)
                o_io_wr <= 1'b0;
            if (w_rd_ack) begin
                o_io_rd <= 1'b0;
                r_gap   <= ~w_hit & ~w_last;
            end
        end
    end
endmodule

// File: rtl/apu_init_sequencer.sv
// apu_init_sequencer: replays a ROM command table as I/O-bus transactions while holding the CPU
module apu_init_sequencer
    import apu_pkg::*;
#(
    parameter int                ROM_AW      = 10,
    parameter logic [ROM_AW-1:0] BASE_ADDR   = '0,
    parameter int                DELAY_SHIFT = 4,
    parameter int                MAX_POLL    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_cpu_hold,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    output logic [15:0]       o_io_addr,
    output logic [7:0]        o_io_wdata,
    output logic              o_io_wr,
    output logic              o_io_rd,
    input  logic [7:0]        i_io_rdata,
    input  logic              i_io_ack
);
    localparam int CW = 8 + DELAY_SHIFT;
    state_t        r_state;
    logic [7:0]    r_cmd, r_alo, r_ahi, r_dat;
    logic [CW-1:0] r_cnt;
    logic          w_wr_go, w_rd_go, w_wr_done, w_rd_match, w_rd_retry, w_rd_fail;
    assign w_wr_go = r_state == EXEC && r_cmd == CMD_WR;
    assign w_rd_go = r_state == EXEC && r_cmd == CMD_POLL;
    apu_io_master #(.MAX_POLL(MAX_POLL)) u_io (
        .clk        (clk),
        .rst        (rst),
        .i_wr_go    (w_wr_go),
        .i_rd_go    (w_rd_go),
        .i_addr     ({r_ahi, r_alo}),
        .i_data     (r_dat),
        .i_io_ack   (i_io_ack),
        .i_io_rdata (i_io_rdata),
        .o_io_wr    (o_io_wr),
        .o_io_rd    (o_io_rd),
        .o_io_addr  (o_io_addr),
        .o_io_wdata (o_io_wdata),
        .o_wr_done  (w_wr_done),
        .o_rd_match (w_rd_match),
        .o_rd_retry (w_rd_retry),
        .o_rd_fail  (w_rd_fail)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_cpu_hold <= 1'b1;
            o_rom_addr <= BASE_ADDR;
            {r_cmd, r_alo, r_ahi, r_dat} <= '0;
            r_cnt      <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state    <= F_CMD;
                    o_busy     <= 1'b1;
                    o_cpu_hold <= 1'b1;
                    o_err      <= 1'b0;
                    o_rom_addr <= BASE_ADDR;
                end
                F_CMD, F_ALO, F_AHI, F_DAT: begin
                    // bytes shift in so that after F_DAT r_cmd holds the first byte of the record
                    {r_cmd, r_alo, r_ahi, r_dat} <= {r_alo, r_ahi, r_dat, i_rom_data};
                    if (r_state == F_CMD && i_rom_data == CMD_END) begin
                        r_state    <= DONE;
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        o_cpu_hold <= 1'b0;
                    end else if (&o_rom_addr) begin
                        r_state    <= ERR;
                        o_err      <= 1'b1;
                        o_busy     <= 1'b0;
                        o_cpu_hold <= 1'b0;
                    end else begin
                        o_rom_addr <= o_rom_addr + 1'b1;
                        r_state    <= r_state == F_DAT ? EXEC : state_t'(r_state + 4'd1);
                    end
                end
                EXEC: case (r_cmd)
                    CMD_WR:   r_state <= IO_WR;
                    CMD_POLL: r_state <= IO_RD;
                    CMD_DLY: begin
                        r_state <= DELAY;
                        r_cnt   <= CW'(r_dat) << DELAY_SHIFT;
                    end
                    default: begin
                        r_state    <= ERR;
                        o_err      <= 1'b1;
                        o_busy     <= 1'b0;
                        o_cpu_hold <= 1'b0;
                    end
                endcase
                IO_WR: if (w_wr_done) r_state <= F_CMD;
                IO_RD: begin
                    if (w_rd_match)
                        r_state <= F_CMD;
                    else if (w_rd_retry)
                        r_state <= POLL_GAP;
                    else if (w_rd_fail) begin
                        r_state    <= ERR;
                        o_err      <= 1'b1;
                        o_busy     <= 1'b0;
                        o_cpu_hold <= 1'b0;
                    end
                end
                POLL_GAP: r_state <= IO_RD;
                DELAY: begin
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= r_cnt == '0 ? F_CMD : DELAY;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apu_init_sequencer.sv
// tb_apu_init_sequencer: randomized table replay checked against a record-level reference model
module tb_apu_init_sequencer;
    import apu_pkg::*;
    localparam int MAXP = 4;
    typedef logic [24:0] tx_t;
    logic clk = 1'b0;
    logic rst, i_start, o_busy, o_done, o_err, o_cpu_hold;
    logic [9:0] o_rom_addr;
    logic [7:0] i_rom_data, o_io_wdata, i_io_rdata;
    logic [15:0] o_io_addr;
    logic o_io_wr, o_io_rd, i_io_ack;
    logic [7:0] rom [1024];
    tx_t exp_q[$], obs_q[$];
    logic [7:0] rd_q[$];
    int n_chk = 0, n_err = 0;
    int lat = 0, exp_t, stab_err, wc;
    logic exp_err, hold_ack = 1'b0, spur = 1'b0, first;
    logic [15:0] cap_addr;
    logic [7:0] cap_wdata;

    always #5 clk = ~clk;
    assign i_rom_data = rom[o_rom_addr];

    apu_init_sequencer #(.MAX_POLL(MAXP)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_cpu_hold(o_cpu_hold), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
        .o_io_addr(o_io_addr), .o_io_wdata(o_io_wdata), .o_io_wr(o_io_wr), .o_io_rd(o_io_rd),
        .i_io_rdata(i_io_rdata), .i_io_ack(i_io_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus slave: acks each request after lat wait cycles, logs it and checks request stability
    initial begin
        i_io_ack = 1'b0;
        i_io_rdata = 8'h00;
        wc = 0;
        first = 1'b1;
        forever begin
            @(negedge clk);
            i_io_ack = 1'b0;
            if (rst || !(o_io_wr || o_io_rd)) begin
                wc = 0;
                first = 1'b1;
                if (spur && $urandom_range(0, 3) == 0) i_io_ack = 1'b1;
            end else begin
                if (first) begin
                    cap_addr = o_io_addr;
                    cap_wdata = o_io_wdata;
                    first = 1'b0;
                end else if (o_io_addr != cap_addr || (o_io_wr && o_io_wdata != cap_wdata))
                    stab_err++;
                if (!hold_ack && wc == lat) begin
                    i_io_ack = 1'b1;
                    i_io_rdata = (o_io_rd && rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    obs_q.push_back({o_io_rd, o_io_addr, o_io_rd ? i_io_rdata : o_io_wdata});
                    first = 1'b1;
                    wc = 0;
                end else wc++;
            end
        end
    end

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 8'hFF;
    endtask

    task automatic put(input int a, input logic [31:0] rec);
        rom[a] = rec[31:24];
        rom[a+1] = rec[23:16];
        rom[a+2] = rec[15:8];
        rom[a+3] = rec[7:0];
    endtask

    // reference: walk the table record by record, accumulating bus traffic and cycle cost
    task automatic plan(input int fm);
        int a, m;
        logic [7:0] c, d, r;
        logic [15:0] ad;
        a = 0;
        exp_t = 1;
        exp_err = 1'b0;
        exp_q.delete();
        rd_q.delete();
        forever begin
            c = rom[a];
            if (c == CMD_END) begin
                exp_t += 1;
                break;
            end
            ad = {rom[a+2], rom[a+1]};
            d = rom[a+3];
            exp_t += 5;
            if (c == CMD_WR) begin
                exp_q.push_back({1'b0, ad, d});
                exp_t += lat + 1;
            end else if (c == CMD_DLY) begin
                exp_t += (int'(d) << 4) + 1;
            end else if (c == CMD_POLL) begin
                m = fm >= 0 ? fm : $urandom_range(0, 3);
                for (int i = 0; i < m && i < MAXP; i++) begin
                    r = d ^ 8'($urandom_range(1, 255));
                    rd_q.push_back(r);
                    exp_q.push_back({1'b1, ad, r});
                    exp_t += lat + 2;
                end
                if (m >= MAXP) begin
                    exp_t -= 1;
                    exp_err = 1'b1;
                    break;
                end
                rd_q.push_back(d);
                exp_q.push_back({1'b1, ad, d});
                exp_t += lat + 1;
            end else begin
                exp_err = 1'b1;
                break;
            end
            a += REC_LEN;
        end
    endtask

    task automatic run(input int l, input int fm, input int restart, input string tag);
        int t;
        lat = l;
        plan(fm);
        obs_q.delete();
        stab_err = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        t = 1;
        chk({tag, " busy"}, o_busy, 1);
        while (!(o_done || o_err) && t < 5000) begin
            i_start = (t == restart);
            @(negedge clk);
            t++;
        end
        i_start = 1'b0;
        chk({tag, " latency"}, t, exp_t);
        chk({tag, " done"}, o_done, !exp_err);
        chk({tag, " err"}, o_err, exp_err);
        chk({tag, " busy_end"}, o_busy, 0);
        chk({tag, " hold_end"}, o_cpu_hold, 0);
        @(negedge clk);
        chk({tag, " done_pulse"}, o_done, 0);
        chk({tag, " err_sticky"}, o_err, exp_err);
        chk({tag, " ntx"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s tx%0d", tag, i), obs_q[i], exp_q[i]);
        chk({tag, " stable"}, stab_err, 0);
    endtask

    initial begin
        int t, n;
        logic [31:0] rec;
        rst = 1'b1;
        i_start = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst busy", o_busy, 0);
        chk("rst done", o_done, 0);
        chk("rst err", o_err, 0);
        chk("rst hold", o_cpu_hold, 1);
        chk("rst wr", o_io_wr, 0);
        chk("rst rd", o_io_rd, 0);
        chk("rst io_addr", o_io_addr, 0);
        chk("rst io_wdata", o_io_wdata, 0);
        chk("rst rom_addr", o_rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        put(0, 32'h01F73F80);
        put(4, 32'h01F77F7A);
        run(2, -1, 0, "wr2");
        clear_rom();
        run(0, -1, 0, "empty");
        put(0, 32'h02000003);
        run(1, -1, 10, "dly");
        clear_rom();
        put(0, 32'h03BE225A);
        run(1, 2, 0, "poll");
        run(0, 4, 0, "pollfail");
        clear_rom();
        put(0, 32'h01123456);
        put(4, 32'h07000000);
        run(1, -1, 0, "illegal");

        clear_rom();
        put(0, 32'h01ABCD11);
        put(4, 32'h01ABCE22);
        hold_ack = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        t = 0;
        while (!o_io_wr && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hold wr_up", o_io_wr, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst wr", o_io_wr, 0);
        chk("midrst busy", o_busy, 0);
        chk("midrst rom_addr", o_rom_addr, 0);
        chk("midrst hold", o_cpu_hold, 1);
        rst = 1'b0;
        hold_ack = 1'b0;
        run(0, -1, 0, "replay");

        spur = 1'b1;
        for (int k = 0; k < 25; k++) begin
            clear_rom();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0: rec = {8'h01, 16'($urandom), 8'($urandom)};
                    1: rec = {8'h02, 16'($urandom), 8'($urandom_range(0, 3))};
                    default: rec = {8'h03, 16'($urandom), 8'($urandom)};
                endcase
                put(i * REC_LEN, rec);
            end
            if ($urandom_range(0, 3) == 0) rom[n * REC_LEN] = 8'($urandom_range(4, 203));
            run($urandom_range(0, 3), -1, 0, $sformatf("rnd%0d", k));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
